// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: handshaked byte/half/word data memory with an INIT fill pass.
// Define DMEM_PATTERN_INIT_EN to fill word[i] = i*4 during INIT (default fill is 0).

module data_memory_ctrl #(
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [1:0]            ReqSize,
  input  logic                  ReqSigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic                  RespValid,
  output logic                  RespError,
  output logic [31:0]           DataOut,
  output logic                  InitDone
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH);
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [31:0]   dout_q, dout_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem_q [DEPTH];

  logic [IW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_data;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          size_err;
  logic          req_err;
  logic [31:0]   fill_word;

  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wd;

  // Decode address, classify errors, format load data and store lanes
  always_comb begin
    word_idx = Address[IW+1:2];
    lane     = Address[1:0];
    rd_word  = mem_q[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    size_err = 1'b0;
    ld_data  = rd_shift;
    st_be    = 4'hF;
    st_data  = DataIn;
    unique case (1'b1)
      ReqSize == 2'b00: begin
        ld_data = {{24{ReqSigned & rd_shift[7]}}, rd_shift[7:0]};
        st_be   = 4'b0001 << lane;
        st_data = {4{DataIn[7:0]}};
      end
      ReqSize == 2'b01: begin
        size_err = Address[0];
        ld_data  = {{16{ReqSigned & rd_shift[15]}}, rd_shift[15:0]};
        st_be    = 4'b0011 << lane;
        st_data  = {2{DataIn[15:0]}};
      end
      ReqSize == 2'b10: begin
        size_err = (lane != 2'b00);
      end
      default: begin
        size_err = 1'b1;
      end
    endcase
    req_err = size_err | ({1'b0, Address} >= LIMIT);
  end

  // Value written to each word during the INIT pass
  always_comb begin
`ifdef DMEM_PATTERN_INIT_EN
    fill_word = 32'(idx_q) << 2;
`else
    fill_word = '0;
`endif
  end

  // Next-state, response and memory-write control
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = done_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    dout_d  = '0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    mem_idx = idx_q;
    mem_be  = 4'hF;
    mem_wd  = fill_word;
    unique case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_IDLE: begin
        if (ReqValid) begin
          if (req_err) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else if (ReqWrite) begin
            valid_d = 1'b1;
            mem_we  = 1'b1;
            mem_idx = word_idx;
            mem_be  = st_be;
            mem_wd  = st_data;
          end else if (READ_LATENCY == 1) begin
            valid_d = 1'b1;
            dout_d  = ld_data;
          end else begin
            state_d = S_BUSY;
            ready_d = 1'b0;
            cnt_d   = LAT_M1;
            rdata_d = ld_data;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 2'd1) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          valid_d = 1'b1;
          dout_d  = rdata_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Control and output registers; reset restarts the INIT pass
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array: per-lane writes, contents come from INIT not reset
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
        end
      end
    end
  end

  assign ReqReady  = ready_q;
  assign InitDone  = done_q;
  assign RespValid = valid_q;
  assign RespError = err_q;
  assign DataOut   = dout_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench, three instances with READ_LATENCY 2/1/3.
// Expected responses are queued at accept and checked by a separate monitor.

module tb_data_memory_ctrl;

  localparam int DEPTH = 32;
`ifdef DMEM_PATTERN_INIT_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        Clock  = 1'b0;
  logic        ResetN = 1'b1;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] addr       [3];
  logic [31:0] din        [3];
  logic        resp_valid [3];
  logic        resp_error [3];
  logic [31:0] resp_data  [3];
  logic        init_done  [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          inst;
    bit          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq [$];

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_ctrl #(
      .DEPTH       (DEPTH),
      .READ_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 3)),
      .ADDR_WIDTH  (32)
    ) u_dut (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .ReqValid (req_valid[g]),
      .ReqReady (req_ready[g]),
      .ReqWrite (req_write[g]),
      .ReqSize  (req_size[g]),
      .ReqSigned(req_signed[g]),
      .Address  (addr[g]),
      .DataIn   (din[g]),
      .RespValid(resp_valid[g]),
      .RespError(resp_error[g]),
      .DataOut  (resp_data[g]),
      .InitDone (init_done[g])
    );
  end

  function automatic int lat_of(input int g);
    return g == 0 ? 2 : (g == 1 ? 1 : 3);
  endfunction

  function automatic logic [31:0] fill(input int i);
    return PAT ? 32'(i * 4) : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Present a request, wait (bounded) for acceptance, queue the expectation.
  task automatic issue(input int g, input bit wr, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] d, input bit e,
                       input logic [31:0] x, input bit want,
                       output int acc);
    int n;
    int lat;
    lat = (wr || e) ? 1 : lat_of(g);
    req_write[g]  = wr;
    req_size[g]   = sz;
    req_signed[g] = sg;
    addr[g]       = a;
    din[g]        = d;
    req_valid[g]  = 1'b1;
    n = 0;
    while (req_ready[g] !== 1'b1 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (req_ready[g] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: ReqReady=%b, required 1",
               g, req_ready[g]);
      req_valid[g] = 1'b0;
      acc = -1;
      return;
    end
    @(posedge Clock);
    #1;
    acc = cyc;
    if (want) sbq.push_back('{inst: g, err: e, data: x, due: acc + lat - 1});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0",
               sbq.size());
      sbq.delete();
    end
  endtask

  task automatic op(input int g, input bit wr, input logic [1:0] sz,
                    input bit sg, input logic [31:0] a,
                    input logic [31:0] d, input bit e,
                    input logic [31:0] x);
    int acc;
    issue(g, wr, sz, sg, a, d, e, x, 1'b1, acc);
    req_valid[g] = 1'b0;
    drain();
  endtask

  // Called right after ResetN is released at a negedge.
  task automatic init_wait();
    repeat (31) @(posedge Clock);
    @(negedge Clock);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("init_done_early dut%0d", g), 32'(init_done[g]), 32'h0);
      chk($sformatf("init_ready_early dut%0d", g), 32'(req_ready[g]), 32'h0);
      req_valid[g] = 1'b0;
    end
    @(posedge Clock);
    @(negedge Clock);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("init_done dut%0d", g), 32'(init_done[g]), 32'h1);
      chk($sformatf("init_ready dut%0d", g), 32'(req_ready[g]), 32'h1);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (resp_valid[g] === 1'b1) begin
          if (sbq.size() == 0 || sbq[0].inst != g) begin
            errors++;
            $display("FAIL resp_unexpected dut%0d: got err=%b data=%h, required no response",
                     g, resp_error[g], resp_data[g]);
          end else begin
            e = sbq.pop_front();
            if (resp_error[g] !== e.err || resp_data[g] !== e.data ||
                cyc != e.due) begin
              errors++;
              $display("FAIL resp dut%0d: got err=%b data=%h cyc=%0d, required err=%b data=%h cyc=%0d",
                       g, resp_error[g], resp_data[g], cyc, e.err, e.data, e.due);
            end
          end
        end else if (resp_valid[g] !== 1'b0 || resp_error[g] !== 1'b0 ||
                     resp_data[g] !== 32'h0) begin
          errors++;
          $display("FAIL idle_zero dut%0d: got v=%b err=%b data=%h, required 0/0/0",
                   g, resp_valid[g], resp_error[g], resp_data[g]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          accs [4];
    logic [31:0] w8;

    for (int g = 0; g < 3; g++) begin
      req_valid[g]  = 1'b0;
      req_write[g]  = 1'b0;
      req_size[g]   = 2'b10;
      req_signed[g] = 1'b0;
      addr[g]       = '0;
      din[g]        = '0;
    end
    #1 ResetN = 1'b0;
    repeat (2) @(negedge Clock);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_ready dut%0d", g), 32'(req_ready[g]), 32'h0);
      chk($sformatf("reset_done dut%0d", g), 32'(init_done[g]), 32'h0);
      req_valid[g] = 1'b1;
    end
    ResetN = 1'b1;
    init_wait();

    // Word store/load and ReqReady low while busy (latency 2)
    op(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, acc);
    req_valid[0] = 1'b0;
    @(negedge Clock);
    chk("busy_ready", 32'(req_ready[0]), 32'h0);
    drain();

    // Half store to upper lane, then sub-word loads
    op(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 1'b0, 32'h0);
    op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hBEEFBEEF);
    op(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFBEEF);
    op(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h000000BE);

    // Byte store and extension
    w8 = fill(8);
    w8[15:8] = 8'h80;
    op(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h12345680, 1'b0, 32'h0);
    op(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'hFFFFFF80);
    op(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'h00000080);
    op(0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, {16'h0, w8[15:0]});
    op(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, {{16{w8[15]}}, w8[15:0]});
    op(0, 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0, w8);

    // Errors, then memory unchanged
    op(0, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0);
    op(0, 1'b1, 2'b10, 1'b0, 32'h06, 32'hCAFEF00D, 1'b1, 32'h0);
    op(0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0);
    op(0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h5A5A5A5A, 1'b1, 32'h0);
    op(0, 1'b1, 2'b00, 1'b0, 32'h80000010, 32'h000000EE, 1'b1, 32'h0);
    op(0, 1'b1, 2'b11, 1'b0, 32'h0C, 32'h77777777, 1'b1, 32'h0);
    op(0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, fill(1));
    op(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, fill(0));
    op(0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, fill(3));
    op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hBEEFBEEF);

    // Back-to-back at latency 1: stores then loads with ReqValid held
    for (int i = 0; i < 4; i++)
      issue(1, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'(32'h11111111 * (i + 1)),
            1'b0, 32'h0, 1'b1, accs[i]);
    req_valid[1] = 1'b0;
    drain();
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b_store_gap%0d", i), 32'(accs[i] - accs[i-1]), 32'h1);
    for (int i = 0; i < 4; i++)
      issue(1, 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, 1'b0,
            32'(32'h11111111 * (i + 1)), 1'b1, accs[i]);
    req_valid[1] = 1'b0;
    drain();
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b_load_gap%0d", i), 32'(accs[i] - accs[i-1]), 32'h1);

    // Latency 3, then reset one cycle after a load is accepted
    op(2, 1'b1, 2'b10, 1'b0, 32'h14, 32'hAAAA5555, 1'b0, 32'h0);
    op(2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'hAAAA5555);
    issue(2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, 1'b0, acc);
    req_valid[2] = 1'b0;
    @(posedge Clock);
    #1 ResetN = 1'b0;
    @(negedge Clock);
    chk("midreset_done", 32'(init_done[2]), 32'h0);
    chk("midreset_ready", 32'(req_ready[2]), 32'h0);
    repeat (3) @(negedge Clock);
    ResetN = 1'b1;
    init_wait();
    op(2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, fill(5));
    op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, fill(4));
    op(1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, fill(2));

    repeat (3) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, handshaked data memory for the CPU load/store path.
- Supports byte, half-word and word access with sign or zero extension, and a configurable read latency.
- Flags misaligned and out-of-range accesses.
- A post-reset INIT sequence fills the memory one word per cycle before it accepts any request.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, at least 2.
- READ_LATENCY, 1, cycles from the accepting edge to the response; legal range 1..4.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- Clock  in  1  rising-edge clock.
- ResetN  in  1  reset, asynchronous, active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- ReqSigned  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- Address  in  ADDR_WIDTH  byte address, little-endian.
- DataIn  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- RespValid  out  1  one-cycle response strobe.
- RespError  out  1  qualifies RespValid: access rejected.
- DataOut  out  32  load result; 0 for stores and errors.
- InitDone  out  1  high once INIT has completed.

Behaviour:
- Reset (ResetN low, asynchronous):
  - State becomes INIT and the init index goes to 0.
  - ReqReady=0, RespValid=0, RespError=0, DataOut=0, InitDone=0.
  - Any outstanding request is discarded.
- INIT state:
  - Writes fill value to word[idx] each cycle, idx 0..DEPTH-1; takes exactly DEPTH cycles.
  - Then goes to IDLE with InitDone=1; InitDone stays high until the next reset.
  - ReqValid is ignored during INIT.
- IDLE state:
  - ReqReady=1.
  - Accept when ReqValid and ReqReady are both high at a rising edge (edge E0).
  - On accept, go to BUSY and load the latency counter.
- BUSY state:
  - ReqReady=0. Only one request is ever outstanding.
  - RespValid is high for exactly the one cycle after edge E0+L-1. L = READ_LATENCY for loads; L = 1 for stores and errors.
  - During that response cycle the state is IDLE and ReqReady=1, so the next request can be accepted at the edge that ends the response cycle.
  - With L=1 this gives one access per cycle.
- Decode:
  - Word index = Address[log2(DEPTH)+1:2]; byte lane = Address[1:0].
- Error conditions (evaluated at accept):
  - ReqSize=11.
  - Half access with Address[0]=1.
  - Word access with Address[1:0] != 0.
  - Address >= 4*DEPTH.
  - Result: no memory write, response after 1 cycle, RespError=1, DataOut=0.
- Stores:
  - Only the addressed lanes are written, at E0. The write is visible to any later accepted load.
  - Response: RespValid=1, RespError=0, DataOut=0.
- Loads:
  - Memory is sampled at E0 and piped through READ_LATENCY stages.
  - The addressed byte or half is shifted to bit 0, then extended per ReqSigned; word loads ignore ReqSigned.
- Outputs are registered. RespError and DataOut are 0 whenever RespValid=0.
- Request inputs are sampled only at the accepting edge; their changes while BUSY have no effect.
- Reset mid-operation:
  - The response is dropped.
  - Memory is re-initialised by a full INIT pass.

Optional Feature:
- Macro: DMEM_PATTERN_INIT_EN.
- Defined: INIT writes word[i] = i*4 (word 5 = 0x00000014).
- Undefined: INIT writes 0 to every word.
- INIT timing is DEPTH cycles either way.

Test Plan:
- Init timing: DEPTH=32, release ResetN -> InitDone and ReqReady rise exactly 32 cycles later. A ReqValid held high during INIT produces no response.
- Word store/load: store word 0xDEADBEEF to 0x10, then load word 0x10 with READ_LATENCY=2. -> Store response after 1 cycle with DataOut=0. Load RespValid 2 cycles after accept with DataOut=0xDEADBEEF. ReqReady low in between.
- Byte store and extension: store byte 0x80 to 0x21, then load from 0x21. -> Signed byte reads 0xFFFFFF80; unsigned byte reads 0x00000080. Unsigned half at 0x20 reads 0x00008000 when word 8 was 0.
- Errors: half load at 0x03, word store at 0x06, and any access at 0x80 with DEPTH=32. -> Each gives RespValid=1, RespError=1, DataOut=0. A following load shows memory unchanged.
- Back-to-back: READ_LATENCY=1, ReqValid held high for 4 word loads at 0x0/0x4/0x8/0xC -> 4 consecutive RespValid cycles, no bubbles.
- Reset mid-operation and init pattern: assert ResetN low one cycle after a READ_LATENCY=3 load is accepted -> no RespValid, INIT reruns. With DMEM_PATTERN_INIT_EN, load of 0x14 then returns 0x00000014; without it, returns 0.
